// File: rtl/veda_master_if.sv
// Host and memory pins of the veda initiator, bundled for the controller (master)
// and for whatever sits around it: host sequencer plus memory (slave).
interface veda_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_addr;
  logic [4:0]  cmd_len;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        busy;
  logic        done;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_mode;
  logic        mem_reset;
  logic [31:0] mem_data_out;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_len, wr_valid, wr_data, mem_data_out,
    output cmd_ready, wr_ready, rd_valid, rd_data, busy, done,
           mem_we, mem_addr, mem_wdata, mem_mode, mem_reset
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_len, wr_valid, wr_data, mem_data_out,
    input  cmd_ready, wr_ready, rd_valid, rd_data, busy, done,
           mem_we, mem_addr, mem_wdata, mem_mode, mem_reset
  );
endinterface

// File: rtl/veda_master.sv
// Burst initiator for the 32x32 veda scratch memory: read / write / clear commands
// turned into registered memory pin activity, with read data aligned by a valid tracker.
module veda_master #(
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  veda_master_if.master bus
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, CLEAR} state_t;

  state_t          state;
  logic [4:0]      addr;
  logic [4:0]      count;
  logic [RD_LAT:0] vld_pipe;

  assign bus.cmd_ready = (state == IDLE);
  assign bus.wr_ready  = (state == WRITE);
  assign bus.busy      = (state != IDLE);
  assign bus.rd_valid  = vld_pipe[RD_LAT];
  assign bus.rd_data   = bus.mem_data_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      addr          <= '0;
      count         <= '0;
      vld_pipe      <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_mode  <= 1'b1;
      bus.mem_reset <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      bus.mem_we    <= 1'b0;
      bus.mem_reset <= 1'b0;
      bus.done      <= 1'b0;
      // stage 0 marks the cycle an address sits on mem_addr; stage RD_LAT is rd_valid
      vld_pipe      <= {vld_pipe[RD_LAT-1:0], state == READ};
      case (state)
        IDLE: begin
          // mode is released here, one cycle late, so the final write beat still sees mode=0
          bus.mem_mode <= 1'b1;
          if (bus.cmd_valid) begin
            addr  <= bus.cmd_addr;
            count <= bus.cmd_len;
            case (bus.cmd_op)
              2'b00: state <= READ;
              2'b01: begin
                state        <= WRITE;
                bus.mem_mode <= 1'b0;
              end
              2'b10: begin
                state         <= CLEAR;
                bus.mem_reset <= 1'b1;
              end
              default: bus.done <= 1'b1;
            endcase
          end
        end
        WRITE: begin
          bus.mem_mode <= 1'b0;
          if (bus.wr_valid) begin
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= addr;
            bus.mem_wdata <= bus.wr_data;
            addr          <= addr + 5'd1;
            count         <= count - 5'd1;
            if (count == 5'd0) begin
              state    <= IDLE;
              bus.done <= 1'b1;
            end
          end
        end
        READ: begin
          bus.mem_addr <= addr;
          addr         <= addr + 5'd1;
          count        <= count - 5'd1;
          if (count == 5'd0) state <= DRAIN;
        end
        DRAIN: begin
          // leave when only the final stage may still hold a beat: done lands right after it
          if (vld_pipe[RD_LAT-1:0] == '0) begin
            state    <= IDLE;
            bus.done <= 1'b1;
          end
        end
        CLEAR: begin
          state    <= IDLE;
          bus.done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_veda_master.sv
// Bench for veda_master: a veda memory model, a command-level reference memory with
// expected write/read queues, one per-cycle compare process, directed and random commands.
module tb_veda_master;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  veda_master_if bus();
  veda_master #(.RD_LAT(2)) dut (.clk(clk), .reset(reset), .bus(bus));

  // veda memory: address sampled on one edge, data_out valid after the next
  logic [31:0] vmem [32];
  logic [4:0]  vaddr_q;
  always @(posedge clk) begin
    if (bus.mem_reset) for (int i = 0; i < 32; i++) vmem[i] <= 32'h0;
    else if (bus.mem_we && !bus.mem_mode) vmem[bus.mem_addr] <= bus.mem_wdata;
    vaddr_q          <= bus.mem_addr;
    bus.mem_data_out <= vmem[vaddr_q];
  end

  logic [31:0] ref_mem [32];
  logic [36:0] exp_wr [$];
  logic [31:0] exp_rd [$];
  logic [31:0] got_rd [$];
  int checks = 0, failures = 0;
  int nmemwe = 0, nmemrst = 0, ndone = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [36:0] e;
    logic [31:0] r;
    if (!reset) begin
      chk("cmd_ready_vs_busy", 32'(bus.cmd_ready), 32'(!bus.busy));
      if (bus.wr_ready) chk("wr_ready_busy", 32'(bus.busy), 32'd1);
      if (!bus.busy && !bus.mem_we) chk("mode_idle", 32'(bus.mem_mode), 32'd1);
      if (bus.mem_we) begin
        nmemwe++;
        chk("we_mode", 32'(bus.mem_mode), 32'd0);
        chk("we_expected", 32'(exp_wr.size() > 0), 32'd1);
        if (exp_wr.size() > 0) begin
          e = exp_wr.pop_front();
          chk("we_addr", 32'(bus.mem_addr), 32'(e[36:32]));
          chk("we_data", bus.mem_wdata, e[31:0]);
        end
      end
      if (bus.rd_valid) begin
        got_rd.push_back(bus.rd_data);
        chk("rd_expected", 32'(exp_rd.size() > 0), 32'd1);
        if (exp_rd.size() > 0) begin
          r = exp_rd.pop_front();
          chk("rd_data", bus.rd_data, r);
        end
      end
      if (bus.mem_reset) nmemrst++;
      if (bus.done) ndone++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [4:0] a, input logic [4:0] len);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_addr = a; bus.cmd_len = len;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  // pat: write data A0+i instead of random; fixed_gap >= 0 forces idle cycles between beats
  task automatic run_cmd(input logic [1:0] op, input logic [4:0] a, input logic [4:0] len,
                         input int gap_max, input int fixed_gap, input bit pat);
    logic [31:0] data [32];
    int k, d0, mw0, mr0, first_rv, gaps, w;
    for (int i = 0; i <= int'(len); i++) begin
      data[i] = pat ? 32'hA0 + 32'(i) : $urandom;
      if (op == 2'b01) begin
        ref_mem[5'(a + 5'(i))] = data[i];
        exp_wr.push_back({5'(a + 5'(i)), data[i]});
      end
      if (op == 2'b00) exp_rd.push_back(ref_mem[5'(a + 5'(i))]);
    end
    if (op == 2'b10) for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
    d0 = ndone; mw0 = nmemwe; mr0 = nmemrst; first_rv = 0;
    chk("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    issue(op, a, len);
    k = 1;
    if (op == 2'b01) begin
      for (int i = 0; i <= int'(len); i++) begin
        gaps = (i > 0 && fixed_gap >= 0) ? fixed_gap : int'($urandom_range(gap_max, 0));
        repeat (gaps) begin
          bus.wr_valid = 1'b0; bus.wr_data = $urandom;
          chk("no_done_mid_write", 32'(bus.done), 32'd0);
          tick(); k++;
        end
        bus.wr_valid = 1'b1; bus.wr_data = data[i];
        w = 0;
        while (!bus.wr_ready && w < 20) begin tick(); w++; end
        chk("wr_ready_seen", 32'(bus.wr_ready), 32'd1);
        tick(); k++;
        bus.wr_valid = 1'b0; bus.wr_data = $urandom;
      end
      chk("wr_done", 32'(bus.done), 32'd1);
      chk("wr_done_we", 32'(bus.mem_we), 32'd1);
      chk("wr_done_addr", 32'(bus.mem_addr), 32'(5'(a + len)));
      chk("wr_done_busy", 32'(bus.busy), 32'd0);
    end else begin
      while (!bus.done && k < 200) begin
        if (op == 2'b00 && k == 2) chk("rd_first_addr", 32'(bus.mem_addr), 32'(a));
        if (bus.rd_valid && first_rv == 0) first_rv = k;
        tick(); k++;
      end
      chk("done_seen", 32'(bus.done), 32'd1);
      chk("done_busy", 32'(bus.busy), 32'd0);
      case (op)
        2'b00: begin
          chk("rd_first_beat_cycle", 32'(first_rv), 32'd4);
          chk("rd_done_cycle", 32'(k), 32'(5 + int'(len)));
          chk("rd_all_beats", 32'(exp_rd.size()), 32'd0);
        end
        2'b10: begin
          chk("clr_done_cycle", 32'(k), 32'd2);
          chk("clr_pulses", 32'(nmemrst - mr0), 32'd1);
        end
        default: chk("nop_done_cycle", 32'(k), 32'd1);
      endcase
    end
    tick();
    chk("done_once", 32'(ndone - d0), 32'd1);
    chk("done_pulse", 32'(bus.done), 32'd0);
    chk("we_count", 32'(nmemwe - mw0), (op == 2'b01) ? 32'(int'(len) + 1) : 32'd0);
    if (op != 2'b10) chk("no_clear", 32'(nmemrst - mr0), 32'd0);
  endtask

  initial begin
    int d0, mw0, k;
    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wr_valid = 1'b0; bus.wr_data = '0;
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
    repeat (3) tick();
    chk("rst_we", 32'(bus.mem_we), 32'd0);
    chk("rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_wdata", bus.mem_wdata, 32'd0);
    chk("rst_mode", 32'(bus.mem_mode), 32'd1);
    chk("rst_mreset", 32'(bus.mem_reset), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
    reset = 1'b0;
    tick();

    // start from a known-zero memory
    run_cmd(2'b10, 5'd0, 5'd0, 0, -1, 1'b0);

    // wrapping write 30,31,0,1 and the read back
    run_cmd(2'b01, 5'd30, 5'd3, 0, 0, 1'b1);
    chk("vmem30", vmem[30], 32'hA0);
    chk("vmem31", vmem[31], 32'hA1);
    chk("vmem0", vmem[0], 32'hA2);
    chk("vmem1", vmem[1], 32'hA3);
    got_rd.delete();
    run_cmd(2'b00, 5'd30, 5'd3, 0, -1, 1'b0);
    chk("rd_beats", 32'(got_rd.size()), 32'd4);
    for (int i = 0; i < 4 && i < got_rd.size(); i++) chk("rd_pattern", got_rd[i], 32'hA0 + 32'(i));

    // two beats separated by a 3-cycle wr_valid gap
    run_cmd(2'b01, 5'd12, 5'd1, 0, 3, 1'b0);

    // clear then full 32-word read
    run_cmd(2'b10, 5'd7, 5'd9, 0, -1, 1'b0);
    got_rd.delete();
    run_cmd(2'b00, 5'd0, 5'd31, 0, -1, 1'b0);
    chk("clr_rd_beats", 32'(got_rd.size()), 32'd32);
    for (int i = 0; i < got_rd.size(); i++) chk("clr_rd_zero", got_rd[i], 32'h0);

    // reset during the second address of an 8-word read
    run_cmd(2'b01, 5'd10, 5'd7, 1, -1, 1'b0);
    d0 = ndone;
    issue(2'b00, 5'd10, 5'd7);
    tick();
    tick();
    chk("abort_addr", 32'(bus.mem_addr), 32'd11);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("abort_done", 32'(bus.done), 32'd0);
    repeat (4) begin
      tick();
      chk("abort_quiet_rv", 32'(bus.rd_valid), 32'd0);
      chk("abort_quiet_done", 32'(bus.done), 32'd0);
    end
    chk("abort_no_done", 32'(ndone - d0), 32'd0);
    run_cmd(2'b00, 5'd10, 5'd7, 0, -1, 1'b0);

    // cmd_valid held across a read; the held op=11 is taken only once idle
    for (int i = 0; i < 4; i++) exp_rd.push_back(ref_mem[5'(5'd5 + 5'(i))]);
    mw0 = nmemwe; d0 = ndone;
    issue(2'b00, 5'd5, 5'd3);
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b11;
    k = 0;
    while (!bus.done && k < 50) begin
      chk("hold_not_ready", 32'(bus.cmd_ready), 32'd0);
      tick(); k++;
    end
    chk("hold_read_done", 32'(bus.done), 32'd1);
    chk("hold_rd_all", 32'(exp_rd.size()), 32'd0);
    tick();
    bus.cmd_valid = 1'b0;
    chk("hold_nop_done", 32'(bus.done), 32'd1);
    chk("hold_nop_busy", 32'(bus.busy), 32'd0);
    tick();
    chk("hold_done_count", 32'(ndone - d0), 32'd2);
    chk("hold_no_we", 32'(nmemwe - mw0), 32'd0);

    // random command mix against the reference memory
    for (int n = 0; n < 40; n++)
      run_cmd(2'($urandom_range(3, 0)), 5'($urandom), 5'($urandom), 2, -1, 1'b0);
    run_cmd(2'b01, 5'd17, 5'd31, 1, -1, 1'b0);
    run_cmd(2'b00, 5'd3, 5'd31, 0, -1, 1'b0);

    chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
    chk("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
